// File: rtl/bcd_time_load_if.sv
// Keypad digit stream in, binary hour/minute time value out.
// No backpressure: the slave consumes one digit per dig_vld cycle.
interface bcd_time_load_if;
  logic [3:0] dig_in;
  logic       dig_vld;
  logic       abort;
  logic [4:0] ora;
  logic [5:0] minut;
  logic       load;
  logic       err;
  logic       busy;

  modport master (
    output dig_in, dig_vld, abort,
    input  ora, minut, load, err, busy
  );

  modport slave (
    input  dig_in, dig_vld, abort,
    output ora, minut, load, err, busy
  );
endinterface

// File: rtl/bcd_time_load.sv
// Serial BCD HH:MM entry; ora/minut/load/err registered, visible 1 cycle after the accepting edge.
// No backpressure: every dig_vld cycle consumes a digit; abort wins over dig_vld, dig_vld wins over timeout.
module bcd_time_load #(
  parameter int TMO_CYC = 1000
) (
  input  logic            clk,
  input  logic            reset_,
  bcd_time_load_if.slave  bus
);

  localparam int CW = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {H_T, H_U, M_T, M_U} state_t;

  state_t        r_state;
  logic [1:0]    r_ht;
  logic [3:0]    r_hu;
  logic [2:0]    r_mt;
  logic [CW-1:0] r_idle;
  logic [4:0]    r_ora;
  logic [5:0]    r_minut;
  logic          r_load;
  logic          r_err;
  logic          r_busy;

  logic          w_dig_ok;
  logic          w_idle_exp;
  logic [4:0]    w_ora_new;
  logic [5:0]    w_minut_new;

  always_comb begin
    w_dig_ok = 1'b0;
    case (r_state)
      H_T: w_dig_ok = (bus.dig_in <= 4'd2);
      // Hours 20-23 only: units limit tightens once tens is 2.
      H_U: w_dig_ok = (r_ht == 2'd2) ? (bus.dig_in <= 4'd3) : (bus.dig_in <= 4'd9);
      M_T: w_dig_ok = (bus.dig_in <= 4'd5);
      M_U: w_dig_ok = (bus.dig_in <= 4'd9);
      default: w_dig_ok = 1'b0;
    endcase
  end

  assign w_idle_exp = (r_idle == CW'(TMO_CYC - 1));

  // x*10 as (x<<3)+(x<<1); widths hold the worst case of invalid-free inputs.
  assign w_ora_new   = {r_ht, 3'b000} + {2'b00, r_ht, 1'b0} + {1'b0, r_hu};
  assign w_minut_new = {r_mt, 3'b000} + {2'b00, r_mt, 1'b0} + {2'b00, bus.dig_in};

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= H_T;
      r_ht    <= '0;
      r_hu    <= '0;
      r_mt    <= '0;
      r_idle  <= '0;
      r_ora   <= '0;
      r_minut <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_err  <= 1'b0;
      if (bus.abort) begin
        r_state <= H_T;
        r_ht    <= '0;
        r_hu    <= '0;
        r_mt    <= '0;
        r_idle  <= '0;
        r_busy  <= 1'b0;
      end else if (bus.dig_vld) begin
        r_idle <= '0;
        if (!w_dig_ok) begin
          r_err   <= 1'b1;
          r_state <= H_T;
          r_ht    <= '0;
          r_hu    <= '0;
          r_mt    <= '0;
          r_busy  <= 1'b0;
        end else begin
          case (r_state)
            H_T: begin
              r_ht    <= bus.dig_in[1:0];
              r_state <= H_U;
              r_busy  <= 1'b1;
            end
            H_U: begin
              r_hu    <= bus.dig_in;
              r_state <= M_T;
              r_busy  <= 1'b1;
            end
            M_T: begin
              r_mt    <= bus.dig_in[2:0];
              r_state <= M_U;
              r_busy  <= 1'b1;
            end
            default: begin
              r_ora   <= w_ora_new;
              r_minut <= w_minut_new;
              r_load  <= 1'b1;
              r_state <= H_T;
              r_ht    <= '0;
              r_hu    <= '0;
              r_mt    <= '0;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end else if (r_state == H_T) begin
        r_idle <= '0;
      end else if (w_idle_exp) begin
        r_err   <= 1'b1;
        r_state <= H_T;
        r_ht    <= '0;
        r_hu    <= '0;
        r_mt    <= '0;
        r_idle  <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  assign bus.ora   = r_ora;
  assign bus.minut = r_minut;
  assign bus.load  = r_load;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_bcd_time_load.sv
// Directed and random digit streams against an entry-level reference model.
module tb_bcd_time_load;

  localparam int TMO = 8;

  logic clk;
  logic reset_;
  int   checks;
  int   errors;

  // Reference model: digits collected so far in the current entry.
  int   m_n;
  int   m_dig [4];
  int   m_idle;
  int   m_ora;
  int   m_min;
  int   m_load;
  int   m_err;

  bcd_time_load_if bus ();

  bcd_time_load #(.TMO_CYC(TMO)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_idle = 0; m_ora = 0; m_min = 0; m_load = 0; m_err = 0;
  endtask

  task automatic model_step(input int v, input int d, input int a);
    int lim;
    m_load = 0;
    m_err  = 0;
    if (a != 0) begin
      m_n = 0;
      m_idle = 0;
    end else if (v != 0) begin
      m_idle = 0;
      case (m_n)
        0:       lim = 2;
        1:       lim = (m_dig[0] == 2) ? 3 : 9;
        2:       lim = 5;
        default: lim = 9;
      endcase
      if (d > lim) begin
        m_err = 1;
        m_n = 0;
      end else begin
        m_dig[m_n] = d;
        m_n++;
        if (m_n == 4) begin
          m_ora  = m_dig[0] * 10 + m_dig[1];
          m_min  = m_dig[2] * 10 + m_dig[3];
          m_load = 1;
          m_n = 0;
        end
      end
    end else if (m_n > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_err = 1;
        m_n = 0;
        m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic compare_all();
    chk("ora", bus.ora, m_ora);
    chk("minut", bus.minut, m_min);
    chk("load", bus.load, m_load);
    chk("err", bus.err, m_err);
    chk("busy", bus.busy, (m_n > 0) ? 1 : 0);
    chk("load_err_excl", bus.load & bus.err, 0);
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic a);
    @(negedge clk);
    bus.dig_vld = v;
    bus.dig_in  = d;
    bus.abort   = a;
    @(posedge clk);
    model_step(int'(v), int'(d), int'(a));
    #1;
    compare_all();
  endtask

  task automatic send(input logic [3:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ora"}, bus.ora, 0);
    chk({tag, "_minut"}, bus.minut, 0);
    chk({tag, "_load"}, bus.load, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int r;
    logic [3:0] d;
    checks = 0;
    errors = 0;
    model_reset();
    reset_      = 1'b0;
    bus.dig_in  = 4'd0;
    bus.dig_vld = 1'b0;
    bus.abort   = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_ = 1'b1;

    // 17:45
    send(4'd1); send(4'd7); send(4'd4); send(4'd5);
    chk("t1_load", bus.load, 1);
    chk("t1_ora", bus.ora, 17);
    chk("t1_minut", bus.minut, 45);
    idle(1);
    chk("t1_busy_after", bus.busy, 0);
    chk("t1_hold_ora", bus.ora, 17);

    // 23:59 then 00:00 starting in the load cycle
    send(4'd2); send(4'd3); send(4'd5); send(4'd9);
    chk("t2_ora", bus.ora, 23);
    chk("t2_minut", bus.minut, 59);
    chk("t2_load", bus.load, 1);
    send(4'd0);
    chk("t2_busy_in_load_cyc", bus.busy, 1);
    send(4'd0); send(4'd0); send(4'd0);
    chk("t2b_load", bus.load, 1);
    chk("t2b_ora", bus.ora, 0);
    chk("t2b_minut", bus.minut, 0);

    // invalid hour units, then invalid hour tens
    idle(1);
    send(4'd2); send(4'd4);
    chk("t3_err", bus.err, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_ora_kept", bus.ora, 0);
    send(4'd3);
    chk("t3_err_tens", bus.err, 1);

    // abort beats a simultaneous digit
    send(4'd1); send(4'd2);
    step(1'b1, 4'd6, 1'b1);
    chk("t4_no_err", bus.err, 0);
    chk("t4_busy", bus.busy, 0);
    send(4'd0); send(4'd9); send(4'd3); send(4'd0);
    chk("t4_ora", bus.ora, 9);
    chk("t4_minut", bus.minut, 30);

    // timeout, then a digit on the last idle cycle rescues the entry
    send(4'd1);
    idle(TMO - 1);
    chk("t5_no_err_yet", bus.err, 0);
    idle(1);
    chk("t5_err", bus.err, 1);
    chk("t5_busy", bus.busy, 0);
    send(4'd1);
    idle(TMO - 1);
    send(4'd2);
    chk("t5b_no_err", bus.err, 0);
    chk("t5b_busy", bus.busy, 1);
    step(1'b0, 4'd0, 1'b1);

    // reset mid-entry
    send(4'd2); send(4'd0); send(4'd4);
    @(negedge clk);
    bus.dig_vld = 1'b0;
    bus.abort   = 1'b0;
    reset_      = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    model_reset();
    @(negedge clk);
    reset_ = 1'b1;
    send(4'd0); send(4'd5); send(4'd1); send(4'd0);
    chk("t6_ora", bus.ora, 5);
    chk("t6_minut", bus.minut, 10);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
      end else if (r < 65) begin
        if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(0, 15));
        else if ($urandom_range(0, 1) == 0) d = 4'($urandom_range(0, 3));
        else d = 4'($urandom_range(0, 9));
        send(d);
      end else if (r == 99) begin
        idle(TMO + 1);
      end else begin
        idle(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_time_load.md
BCD_TIME_LOAD -- requirements
Module: bcd_time_load

Interface
REQ-001 SHALL have parameter TMO_CYC, default 1000, giving the number of idle cycles allowed mid-entry before the entry is abandoned.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port dig_in, input, 4 bits: BCD digit presented by the keypad/setting logic.
REQ-005 SHALL have port dig_vld, input, 1 bit: dig_in is valid this cycle; one digit is consumed per high cycle.
REQ-006 SHALL have port abort, input, 1 bit: discards the partial entry.
REQ-007 SHALL have port ora, output, 5 bits: binary hour, 0-23.
REQ-008 SHALL have port minut, output, 6 bits: binary minute, 0-59.
REQ-009 SHALL have port load, output, 1 bit: one-cycle pulse while a new ora/minut pair is first presented.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected digit or a timeout.
REQ-011 SHALL have port busy, output, 1 bit: high while an entry is partially complete.

Function
REQ-012 SHALL accept digits serially in this order: hour tens, hour units, minute tens, minute units.
REQ-013 SHALL implement FSM states H_T, H_U, M_T and M_U; each state advances to the next on a valid accepted digit, and M_U returns to H_T.
REQ-014 SHALL reject a digit as invalid when:
- in H_T, dig_in > 2;
- in H_U, dig_in > 9, or dig_in > 3 when the stored hour tens = 2;
- in M_T, dig_in > 5;
- in M_U, dig_in > 9.
REQ-015 SHALL, on an invalid digit, pulse err for one cycle after the accepting edge, return to H_T, discard stored partial digits, and leave ora/minut unchanged.
REQ-016 SHALL store accepted tens digits internally and leave ora/minut untouched until the fourth digit is accepted.
REQ-017 SHALL, on the edge accepting a valid minute units digit, register ora = hour_tens*10 + hour_units and minut = min_tens*10 + min_units.
REQ-018 SHALL compute both values without overflow (ora max 23 in 5 bits, minut max 59 in 6 bits) and assert load in the same cycle the new values first appear.
REQ-019 SHALL hold ora/minut stable between load pulses.
REQ-020 SHALL accept, as a new hour tens digit, a digit that arrives in the cycle where load is high.
REQ-021 SHALL drive busy = 1 in states H_U, M_T and M_U, and busy = 0 in H_T.
REQ-022 SHALL, on abort, return to H_T and discard partial digits, with no err and no load.
REQ-023 SHALL give abort priority over a simultaneous dig_vld; that digit is dropped.
REQ-024 SHALL treat abort in H_T as a no-op.
REQ-025 SHALL keep an idle counter:
- cleared on every accepted digit, on abort, and in H_T;
- incremented each cycle in H_U/M_T/M_U without dig_vld.
REQ-026 SHALL, when the idle counter reaches TMO_CYC, pulse err for one cycle, return to H_T, and discard partial digits.
REQ-027 SHALL give dig_vld priority over timeout in the same cycle.
REQ-028 SHALL never assert load and err in the same cycle.

Reset
REQ-029 SHALL, while reset_ is low, asynchronously force:
- state H_T;
- ora = 0, minut = 0;
- load = 0, err = 0, busy = 0;
- idle counter and stored digits = 0.
REQ-030 SHALL discard any partial entry on reset mid-entry, with no load or err pulse on release.
REQ-031 SHALL treat the first digit after reset_ deasserts as the hour tens digit.

Verification
REQ-032 SHALL pass: digits 1,7,4,5 on consecutive cycles -> one cycle after the "5" edge, load = 1, ora = 17, minut = 45; busy = 0 afterwards.
REQ-033 SHALL pass: digits 2,3,5,9 then 0,0,0,0 -> loads ora = 23/minut = 59, then ora = 0/minut = 0; the second entry starts in the load cycle.
REQ-034 SHALL pass: digits 2,4 -> err pulse after "4", busy = 0, ora/minut keep prior values; then 3 -> err (hour tens > 2).
REQ-035 SHALL pass: digits 1,2, then abort with dig_vld = 1 and dig_in = 6 in the same cycle -> no err, busy = 0; then 0,9,3,0 -> ora = 9, minut = 30.
REQ-036 SHALL pass: TMO_CYC = 8, digit 1, then no dig_vld for 8 cycles -> err pulse, busy = 0; a digit on cycle 8 instead prevents the timeout.
REQ-037 SHALL pass: reset_ low after digits 2,0,4 -> outputs 0 immediately; after release, 0,5,1,0 -> ora = 5, minut = 10.
